// File: rtl/block_cipher_engine.sv
// Iterative multi-round rotate/XOR block cipher with valid/ready on both sides.
// Optional build macro CIPHER_PAD_EN: force the top byte of encrypt inputs to a fixed pad value.
//
// state | meaning
// IDLE  | waiting for an input block, in_ready high
// RUN   | applying one round per clock
// DONE  | result held on out_data until the consumer takes it
module block_cipher_engine #(
   parameter int WORD_W = 64,
   parameter int NWORDS = 4,
   parameter int ROUNDS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_mode,
   input  logic [WORD_W-1:0]        in_key,
   input  logic [NWORDS*WORD_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_mode,
   output logic [NWORDS*WORD_W-1:0] out_data,
   output logic                     busy
);

   localparam int BW = NWORDS * WORD_W;
   localparam int HW = WORD_W / 2;
   localparam int CW = (ROUNDS + 1 > 1) ? $clog2(ROUNDS + 1) : 1;
   localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [BW-1:0]     blk;
   logic              mode_q;
   logic [WORD_W-1:0] key1, key2;
   logic [CW-1:0]     rnd;

   logic              accept;
   logic [WORD_W-1:0] hi_ext, lo_ext, key1_d, key2_d;
   logic [BW-1:0]     enc_blk, dec_blk, load_blk;

   assign in_ready  = (state == IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_data  = blk;
   assign out_mode  = mode_q;

   assign hi_ext = {{HW{1'b0}}, in_key[WORD_W-1:HW]};
   assign lo_ext = {{HW{1'b0}}, in_key[HW-1:0]};
   assign key1_d = hi_ext + lo_ext;
   assign key2_d = hi_ext - lo_ext;

   always_comb begin
      load_blk = in_data;
`ifdef CIPHER_PAD_EN
      if (!in_mode)
         load_blk[BW-1 -: 8] = 8'((BW - 8) % 256);
`endif
   end

   // Word i of the encrypt output lands one word lower; decrypt undoes exactly that.
   always_comb begin
      logic [WORD_W-1:0] w, t, u;
      enc_blk = '0;
      dec_blk = '0;
      for (int i = 0; i < NWORDS; i++) begin
         w = blk[i*WORD_W +: WORD_W];
         t = {w[0], w[WORD_W-1:1]} ^ key2 ^ ((i == 0) ? key1 : '0);
         enc_blk[((i + NWORDS - 1) % NWORDS)*WORD_W +: WORD_W] = t;
         u = blk[((i + NWORDS - 1) % NWORDS)*WORD_W +: WORD_W] ^ key2 ^ ((i == 0) ? key1 : '0);
         dec_blk[i*WORD_W +: WORD_W] = {u[WORD_W-2:0], u[WORD_W-1]};
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (rnd == LAST_RND) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blk    <= '0;
         mode_q <= 1'b0;
         key1   <= '0;
         key2   <= '0;
         rnd    <= '0;
      end else if (accept) begin
         blk    <= load_blk;
         mode_q <= in_mode;
         key1   <= key1_d;
         key2   <= key2_d;
         rnd    <= '0;
      end else if (state == RUN) begin
         blk <= mode_q ? dec_blk : enc_blk;
         rnd <= rnd + 1'b1;
      end
   end

endmodule

// File: tb/tb_block_cipher_engine.sv
// Bench for block_cipher_engine: three instances (1, 3 and 4 rounds) checked against a reference model.
module tb_block_cipher_engine;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst [NI];
   logic         in_valid [NI];
   logic         in_mode [NI];
   logic         out_ready [NI];
   logic [63:0]  in_key [NI];
   logic [255:0] in_data [NI];
   logic         in_ready [NI];
   logic         out_valid [NI];
   logic         out_mode [NI];
   logic         busy [NI];
   logic [255:0] out_data [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      block_cipher_engine #(
         .WORD_W(64), .NWORDS(4), .ROUNDS(g == 0 ? 1 : (g == 1 ? 3 : 4))
      ) u_dut (
         .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .in_mode(in_mode[g]), .in_key(in_key[g]), .in_data(in_data[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_mode(out_mode[g]),
         .out_data(out_data[g]), .busy(busy[g])
      );
   end

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [255:0] data;
      logic         mode;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int           g;
      logic         mode;
      logic [63:0]  key;
      logic [255:0] data;
      logic [255:0] exp;
   } vec_t;
   vec_t vt[6];

   function automatic int rounds_of(input int g);
      return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
   endfunction

   function automatic logic [255:0] padfix(input logic [255:0] d);
      logic [255:0] r;
      r = d;
`ifdef CIPHER_PAD_EN
      r[255:248] = 8'hF8;
`endif
      return r;
   endfunction

   function automatic logic [255:0] model(input logic m, input logic [63:0] k,
                                          input logic [255:0] d, input int nr);
      logic [63:0] k1, k2, x, t [4];
      logic [255:0] w;
      k1 = {32'b0, k[63:32]} + {32'b0, k[31:0]};
      k2 = {32'b0, k[63:32]} - {32'b0, k[31:0]};
      w  = m ? d : padfix(d);
      for (int r = 0; r < nr; r++) begin
         if (!m) begin
            for (int i = 0; i < 4; i++) begin
               x = w[i*64 +: 64];
               t[i] = {x[0], x[63:1]} ^ k2 ^ ((i == 0) ? k1 : 64'd0);
            end
            w = {t[0], t[3], t[2], t[1]};
         end else begin
            t[0] = w[255:192];
            t[1] = w[63:0];
            t[2] = w[127:64];
            t[3] = w[191:128];
            for (int i = 0; i < 4; i++) begin
               x = t[i] ^ k2 ^ ((i == 0) ? k1 : 64'd0);
               w[i*64 +: 64] = {x[62:0], x[63]};
            end
         end
      end
      return w;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int g, input logic m, input logic [63:0] k,
                        input logic [255:0] d, input logic [255:0] exp);
      int n;
      n = 0;
      while (!in_ready[g] && n < 20) begin
         tick();
         n++;
      end
      check("in_ready_wait", in_ready[g], 1'b1);
      in_valid[g]  = 1'b1;
      in_mode[g]   = m;
      in_key[g]    = k;
      in_data[g]   = d;
      out_ready[g] = 1'b0;
      tick();
      in_valid[g] = 1'b0;
      sb.push_back('{exp, m});
      check("busy_run", busy[g], 1'b1);
   endtask

   task automatic wait_out(input int g, output logic [255:0] res);
      int n;
      exp_t e;
      n = 0;
      while (!out_valid[g] && n < 50) begin
         tick();
         n++;
      end
      check("latency", n, rounds_of(g));
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         res = out_data[g];
      end else begin
         e = sb.pop_front();
         check("out_data", out_data[g], e.data);
         check("out_mode", out_mode[g], e.mode);
         res = out_data[g];
      end
   endtask

   task automatic release_out(input int g);
      out_ready[g] = 1'b1;
      tick();
      out_ready[g] = 1'b0;
      check("release_valid", out_valid[g], 1'b0);
      check("release_in_ready", in_ready[g], 1'b1);
      check("release_busy", busy[g], 1'b0);
   endtask

   task automatic do_block(input int g, input logic m, input logic [63:0] k,
                           input logic [255:0] d, input logic [255:0] exp,
                           output logic [255:0] res);
      start(g, m, k, d, exp);
      wait_out(g, res);
      release_out(g);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] r, r2, d, a_exp, p;
      logic [63:0]  kk;
      kk = 64'h0123456789ABCDEF;

      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b1; in_valid[i] = 1'b0; in_mode[i] = 1'b0; out_ready[i] = 1'b0;
         in_key[i] = '0; in_data[i] = '0;
      end
      tick();
      tick();
      for (int i = 0; i < NI; i++) begin
         check("rst_out_valid", out_valid[i], 1'b0);
         check("rst_out_data", out_data[i], 256'd0);
         check("rst_out_mode", out_mode[i], 1'b0);
         check("rst_busy", busy[i], 1'b0);
         check("rst_in_ready", in_ready[i], 1'b0);
         rst[i] = 1'b0;
      end
      tick();
      for (int i = 0; i < NI; i++) check("post_rst_in_ready", in_ready[i], 1'b1);

      vt[0] = '{0, 1'b0, 64'd15, 256'd20, model(1'b0, 64'd15, 256'd20, 1)};
      vt[1] = '{0, 1'b1, 64'd15, vt[0].exp, model(1'b1, 64'd15, vt[0].exp, 1)};
      d = rnd256();
      vt[2] = '{0, 1'b0, 64'd0, d, model(1'b0, 64'd0, d, 1)};
      d = rnd256();
      vt[3] = '{1, 1'b0, kk, d, model(1'b0, kk, d, 3)};
      d = rnd256();
      vt[4] = '{2, 1'b1, 64'hFFFF_FFFF_0000_0001, d, model(1'b1, 64'hFFFF_FFFF_0000_0001, d, 4)};
      d = rnd256();
      vt[5] = '{0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, d, model(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, d, 1)};

      for (int i = 0; i < 6; i++) begin
         do_block(vt[i].g, vt[i].mode, vt[i].key, vt[i].data, vt[i].exp, r);
`ifndef CIPHER_PAD_EN
         if (i == 0)
            check("spec_vector", r, {64'hFFFFFFFFFFFFFFF4, 64'hFFFFFFFFFFFFFFF1,
                                     64'hFFFFFFFFFFFFFFF1, 64'hFFFFFFFFFFFFFFF1});
         if (i == 1)
            check("spec_roundtrip", r, 256'd20);
`endif
      end

      // three-round encrypt/decrypt round trip
      d = rnd256();
      do_block(1, 1'b0, kk, d, model(1'b0, kk, d, 3), r);
      do_block(1, 1'b1, kk, r, model(1'b1, kk, r, 3), r2);
      check("rt3_recovered", r2, padfix(d));

      // backpressure: result held, new input ignored
      d = rnd256();
      a_exp = model(1'b0, kk, d, 1);
      start(0, 1'b0, kk, d, a_exp);
      wait_out(0, r);
      for (int c = 0; c < 5; c++) begin
         in_valid[0] = 1'b1;
         in_mode[0]  = 1'b1;
         in_data[0]  = rnd256();
         tick();
         check("bp_hold_data", out_data[0], a_exp);
         check("bp_hold_mode", out_mode[0], 1'b0);
         check("bp_in_ready", in_ready[0], 1'b0);
         check("bp_valid", out_valid[0], 1'b1);
      end
      in_valid[0] = 1'b0;
      release_out(0);
      d = rnd256();
      do_block(0, 1'b0, 64'd77, d, model(1'b0, 64'd77, d, 1), r);

      // reset during round 2 of a four-round block
      d = rnd256();
      start(2, 1'b0, kk, d, model(1'b0, kk, d, 4));
      tick();
      rst[2] = 1'b1;
      tick();
      check("mid_rst_valid", out_valid[2], 1'b0);
      check("mid_rst_data", out_data[2], 256'd0);
      check("mid_rst_busy", busy[2], 1'b0);
      check("mid_rst_in_ready", in_ready[2], 1'b0);
      if (sb.size() > 0) void'(sb.pop_front());
      rst[2] = 1'b0;
      tick();
      check("after_rst_in_ready", in_ready[2], 1'b1);
      d = rnd256();
      do_block(2, 1'b0, kk, d, model(1'b0, kk, d, 4), r);
      do_block(2, 1'b1, kk, r, model(1'b1, kk, r, 4), r2);
      check("after_rst_rt", r2, padfix(d));

      // pad behaviour
      p = rnd256();
      p[255:248] = 8'hAA;
      do_block(0, 1'b0, kk, p, model(1'b0, kk, p, 1), r);
      do_block(0, 1'b1, kk, r, model(1'b1, kk, r, 1), r2);
`ifdef CIPHER_PAD_EN
      check("pad_top_byte", r2[255:248], 8'hF8);
`else
      check("pad_top_byte", r2[255:248], 8'hAA);
`endif
      check("pad_low_bits", r2[247:0], p[247:0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
